serdes_link_ctrl: RTL and testbench
===================================

Name: serdes_link_ctrl

Overview:
Link-layer controller that sequences the 8-bit serializer/deserializer pair.
- TX: accepts parallel words over valid/ready, schedules one word per WIDTH clocks into the serializer with a load strobe, and frames the stream with a periodic SYNC word, filling empty slots with IDLE.
- RX: consumes deserializer word strobes, acquires and tracks frame alignment via SYNC, and forwards payload words.
- Sits between the packet logic and the SerDes datapath.

Parameters:
WIDTH, 8, word width in bits
LOG_WIDTH, 3, log2(WIDTH); slot bit-counter width
SYNC_WORD, 8'hBC, framing marker sent at the start of every frame
IDLE_WORD, 8'h3C, filler sent in data slots with no upstream data
FRAME_LEN, 16, data slots between consecutive SYNC words (2..255)
LOCK_CNT, 3, consecutive correctly spaced SYNCs required to declare lock
LOSS_CNT, 2, consecutive missing SYNCs that drop lock

Ports:
clock_in  input  1  single system clock, rising edge
reset_n  input  1  asynchronous active-low reset
s_data  input  WIDTH  upstream TX payload word
s_valid  input  1  s_data valid
s_ready  output  1  controller accepts s_data this cycle
ser_data  output  WIDTH  parallel word to serializer din
ser_load  output  1  one-cycle pulse: ser_data holds a new word
de_data  input  WIDTH  parallel word from deserializer dout
de_valid  input  1  one-cycle strobe: de_data holds a new word
m_data  output  WIDTH  RX payload word
m_valid  output  1  one-cycle strobe: m_data valid
link_locked  output  1  RX frame alignment acquired
err_count  output  8  saturating count of SYNC misses while locked

Behaviour:
- Reset (async, reset_n=0): all outputs 0. Bit counter 0. TX FSM in T_SYNC. RX FSM in R_HUNT. All internal counters 0.
- TX slot timer: LOG_WIDTH-bit counter increments every clock and wraps WIDTH-1 -> 0. Slot boundary = counter==WIDTH-1.
- At each slot-boundary edge, ser_data is registered and ser_load is high for the following single cycle.
  - First ser_load occurs WIDTH cycles after reset release, carrying SYNC_WORD.
  - ser_data holds its value between loads.
- TX FSM:
  - T_SYNC: next slot is SYNC_WORD, then go to T_DATA with slot_idx=0.
  - T_DATA: next slot is a data slot; slot_idx increments. After FRAME_LEN data slots, return to T_SYNC.
- s_ready is combinational: high only when counter==WIDTH-1 and the FSM is in T_DATA.
  - Transfer = s_valid && s_ready; s_data is loaded into ser_data on that edge.
  - If s_valid=0 at a data-slot boundary, IDLE_WORD is loaded instead.
  - s_valid held with no s_ready: word stays pending, no loss.
  - Payload values equal to SYNC_WORD or IDLE_WORD are forbidden upstream (not escaped).
- RX is evaluated only on de_valid=1 cycles; the position counter counts received words.
  - R_HUNT: de_data==SYNC_WORD -> R_VERIFY, good=1, pos=0.
  - R_VERIFY: pos increments per word. At pos==FRAME_LEN (the expected SYNC slot): if SYNC_WORD, good++ and pos=0, and good reaching LOCK_CNT -> R_LOCKED; otherwise -> R_HUNT, good=0.
  - R_LOCKED: link_locked=1.
    - Data slots with de_data!=IDLE_WORD: m_data<=de_data and m_valid=1 on the next cycle (latency 1 clock after de_valid).
    - Expected SYNC slot holding SYNC_WORD: miss=0.
    - Expected SYNC slot without SYNC_WORD: miss++, err_count++ (saturates at 255), pos=0 (flywheel keeps the slot timing).
    - miss reaching LOSS_CNT -> R_HUNT; link_locked drops on the same edge.
- No m_valid outside R_LOCKED.
- err_count is cleared only by reset.
- TX and RX operate independently; simultaneous transfer and de_valid are fully supported.

Optional Feature:
SERDES_CTRL_LOOPBACK_EN
- Defined: adds input port lpbk (1 bit). When lpbk=1, the RX path takes ser_data/ser_load in place of de_data/de_valid (internal near-end loopback). lpbk=0 behaves as normal.
- Undefined: port absent; RX always uses de_data/de_valid.

Test Plan:
- Reset release, s_valid=0 -> ser_load every 8 clocks; words SYNC(8'hBC), then 16 x IDLE(8'h3C), then SYNC, repeating.
- s_valid=1 continuously with s_data counting 1..20 -> s_ready one cycle per data slot; slots carry 1..16, SYNC, then 17..20; no word lost or duplicated.
- Feed an aligned TX stream into de_data/de_valid -> link_locked rises on the 3rd SYNC; then m_valid only for non-IDLE words, each 1 clock after de_valid.
- While locked, corrupt one SYNC to 8'h00 -> err_count=1, lock held. Corrupt two consecutive SYNCs -> err_count=3, link_locked=0 at the 2nd miss, R_HUNT re-acquires after 3 good SYNCs.
- Assert reset_n=0 mid-frame and mid-lock -> all outputs 0 immediately; restart reproduces the first scenario.
- With SERDES_CTRL_LOOPBACK_EN, lpbk=1, s_data 8'h55 stream -> link locks and m_data returns 8'h55 words in order.

Source files
------------

// File: rtl/serdes_link_ctrl.sv
// Link-layer controller for an 8-bit SerDes pair: TX slot scheduler with SYNC/IDLE framing, RX frame aligner.
// Optional near-end loopback input lpbk is compiled in when SERDES_CTRL_LOOPBACK_EN is defined.
module serdes_link_ctrl #(
  parameter int                WIDTH     = 8,
  parameter int                LOG_WIDTH = 3,
  parameter logic [WIDTH-1:0]  SYNC_WORD = 8'hBC,
  parameter logic [WIDTH-1:0]  IDLE_WORD = 8'h3C,
  parameter int                FRAME_LEN = 16,
  parameter int                LOCK_CNT  = 3,
  parameter int                LOSS_CNT  = 2
) (
  input  logic             clock_in,
  input  logic             reset_n,
`ifdef SERDES_CTRL_LOOPBACK_EN
  input  logic             lpbk,
`endif
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] ser_data,
  output logic             ser_load,
  input  logic [WIDTH-1:0] de_data,
  input  logic             de_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             link_locked,
  output logic [7:0]       err_count
);

  typedef enum logic {T_SYNC, T_DATA} txState_e;
  typedef enum logic [1:0] {R_HUNT, R_VERIFY, R_LOCKED} rxState_e;

  localparam logic [LOG_WIDTH-1:0] CntLast  = LOG_WIDTH'(WIDTH - 1);
  localparam logic [7:0]           SlotLast = 8'(FRAME_LEN - 1);
  localparam logic [7:0]           PosSync  = 8'(FRAME_LEN);
  localparam logic [7:0]           LockGood = 8'(LOCK_CNT);
  localparam logic [7:0]           LossMiss = 8'(LOSS_CNT);

  logic [LOG_WIDTH-1:0] bitCnt_q, bitCnt_d;
  txState_e             txState_q, txState_d;
  logic [7:0]           slotIdx_q, slotIdx_d;
  logic [WIDTH-1:0]     serData_q, serData_d;
  logic                 serLoad_q, serLoad_d;

  rxState_e             rxState_q, rxState_d;
  logic [7:0]           rxPos_q, rxPos_d;
  logic [7:0]           goodCnt_q, goodCnt_d;
  logic [7:0]           missCnt_q, missCnt_d;
  logic [7:0]           errCnt_q, errCnt_d;
  logic [WIDTH-1:0]     mData_q, mData_d;
  logic                 mValid_q, mValid_d;

  logic                 slotBoundary;
  logic                 xfer;
  logic [WIDTH-1:0]     rxData;
  logic                 rxValid;
  logic                 atSyncSlot;
  logic                 isSync;

  assign slotBoundary = (bitCnt_q == CntLast);
  assign xfer         = s_valid && s_ready;

`ifdef SERDES_CTRL_LOOPBACK_EN
  assign rxData  = lpbk ? serData_q : de_data;
  assign rxValid = lpbk ? serLoad_q : de_valid;
`else
  assign rxData  = de_data;
  assign rxValid = de_valid;
`endif

  assign atSyncSlot = (rxPos_q == PosSync);
  assign isSync     = (rxData == SYNC_WORD);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      bitCnt_q  <= '0;
      txState_q <= T_SYNC;
      slotIdx_q <= '0;
      serData_q <= '0;
      serLoad_q <= 1'b0;
      rxState_q <= R_HUNT;
      rxPos_q   <= '0;
      goodCnt_q <= '0;
      missCnt_q <= '0;
      errCnt_q  <= '0;
      mData_q   <= '0;
      mValid_q  <= 1'b0;
    end else begin
      bitCnt_q  <= bitCnt_d;
      txState_q <= txState_d;
      slotIdx_q <= slotIdx_d;
      serData_q <= serData_d;
      serLoad_q <= serLoad_d;
      rxState_q <= rxState_d;
      rxPos_q   <= rxPos_d;
      goodCnt_q <= goodCnt_d;
      missCnt_q <= missCnt_d;
      errCnt_q  <= errCnt_d;
      mData_q   <= mData_d;
      mValid_q  <= mValid_d;
    end
  end

  // TX: one word is committed to the serializer at every slot boundary.
  always_comb begin
    bitCnt_d  = slotBoundary ? '0 : bitCnt_q + 1'b1;
    txState_d = txState_q;
    slotIdx_d = slotIdx_q;
    serData_d = serData_q;
    serLoad_d = slotBoundary;
    if (slotBoundary) begin
      case (txState_q)
        T_SYNC: begin
          serData_d = SYNC_WORD;
          slotIdx_d = '0;
          txState_d = T_DATA;
        end
        T_DATA: begin
          serData_d = xfer ? s_data : IDLE_WORD;
          slotIdx_d = slotIdx_q + 8'd1;
          if (slotIdx_q == SlotLast) begin
            txState_d = T_SYNC;
          end
        end
        default: txState_d = T_SYNC;
      endcase
    end
  end

  // RX: rxPos counts words since the last expected SYNC slot; in lock it acts as a flywheel.
  always_comb begin
    rxState_d = rxState_q;
    rxPos_d   = rxPos_q;
    goodCnt_d = goodCnt_q;
    missCnt_d = missCnt_q;
    errCnt_d  = errCnt_q;
    mData_d   = mData_q;
    mValid_d  = 1'b0;
    if (rxValid) begin
      case (rxState_q)
        R_HUNT: begin
          if (isSync) begin
            rxState_d = R_VERIFY;
            goodCnt_d = 8'd1;
            rxPos_d   = '0;
          end
        end
        R_VERIFY: begin
          if (atSyncSlot) begin
            rxPos_d = '0;
            if (isSync) begin
              goodCnt_d = goodCnt_q + 8'd1;
              if (goodCnt_q + 8'd1 == LockGood) begin
                rxState_d = R_LOCKED;
                missCnt_d = '0;
              end
            end else begin
              rxState_d = R_HUNT;
              goodCnt_d = '0;
            end
          end else begin
            rxPos_d = rxPos_q + 8'd1;
          end
        end
        R_LOCKED: begin
          if (atSyncSlot) begin
            rxPos_d = '0;
            if (isSync) begin
              missCnt_d = '0;
            end else begin
              missCnt_d = missCnt_q + 8'd1;
              if (errCnt_q != 8'hFF) begin
                errCnt_d = errCnt_q + 8'd1;
              end
              if (missCnt_q + 8'd1 == LossMiss) begin
                rxState_d = R_HUNT;
                goodCnt_d = '0;
                missCnt_d = '0;
              end
            end
          end else begin
            rxPos_d = rxPos_q + 8'd1;
            if (rxData != IDLE_WORD) begin
              mData_d  = rxData;
              mValid_d = 1'b1;
            end
          end
        end
        default: rxState_d = R_HUNT;
      endcase
    end
  end

  always_comb begin
    s_ready     = slotBoundary && (txState_q == T_DATA);
    link_locked = (rxState_q == R_LOCKED);
    ser_data    = serData_q;
    ser_load    = serLoad_q;
    m_data      = mData_q;
    m_valid     = mValid_q;
    err_count   = errCnt_q;
  end

endmodule

// File: tb/tb_serdes_link_ctrl.sv
// Directed self-checking bench for serdes_link_ctrl: TX framing, upstream handshake, RX lock/loss, async reset.
// The loopback scenario is included when SERDES_CTRL_LOOPBACK_EN is defined.
module tb_serdes_link_ctrl;

  logic       clock_in = 1'b0;
  logic       reset_n  = 1'b1;
  logic [7:0] s_data   = '0;
  logic       s_valid  = 1'b0;
  logic       s_ready;
  logic [7:0] ser_data;
  logic       ser_load;
  logic [7:0] de_data  = '0;
  logic       de_valid = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       link_locked;
  logic [7:0] err_count;
`ifdef SERDES_CTRL_LOOPBACK_EN
  logic       lpbk = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  serdes_link_ctrl dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
`ifdef SERDES_CTRL_LOOPBACK_EN
    .lpbk        (lpbk),
`endif
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .ser_data    (ser_data),
    .ser_load    (ser_load),
    .de_data     (de_data),
    .de_valid    (de_valid),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .link_locked (link_locked),
    .err_count   (err_count)
  );

  // Free-running 10-unit clock.
  always #5 clock_in = ~clock_in;

  // Safety net in case a bounded wait is ever miscounted.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and on mismatch counts a failure and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next ser_load, reporting the word, clocks waited and s_ready hits seen.
  task automatic waitLoad(output logic [7:0] word, output int gap, output int readyHits);
    logic found;
    found = 1'b0;
    gap = 0;
    readyHits = 0;
    word = '0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock_in);
      gap++;
      if (ser_load) begin
        word  = ser_data;
        found = 1'b1;
      end else if (s_ready) begin
        readyHits++;
      end
    end
    if (!found) checkOutput("load_timeout", 32'(found), 32'd1);
  endtask

  // Right after reset release with s_valid=0: SYNC, 16 x IDLE, SYNC, each 8 clocks apart.
  task automatic txCheckFromReset(input string phase);
    logic [7:0] w;
    int gap, rdy;
    waitLoad(w, gap, rdy);
    checkOutput($sformatf("%s_first_gap", phase), 32'(gap), 32'd8);
    checkOutput($sformatf("%s_first_sync", phase), 32'(w), 32'hBC);
    checkOutput($sformatf("%s_first_ready", phase), 32'(rdy), 32'd0);
    for (int i = 0; i < 16; i++) begin
      waitLoad(w, gap, rdy);
      checkOutput($sformatf("%s_idle%0d_gap", phase, i), 32'(gap), 32'd8);
      checkOutput($sformatf("%s_idle%0d_word", phase, i), 32'(w), 32'h3C);
      checkOutput($sformatf("%s_idle%0d_ready", phase, i), 32'(rdy), 32'd1);
    end
    waitLoad(w, gap, rdy);
    checkOutput($sformatf("%s_sync2_gap", phase), 32'(gap), 32'd8);
    checkOutput($sformatf("%s_sync2_word", phase), 32'(w), 32'hBC);
    checkOutput($sformatf("%s_sync2_ready", phase), 32'(rdy), 32'd0);
  endtask

  // Presents one deserializer word for a single clock and checks the RX output one clock later.
  task automatic applyStimulus(input logic [7:0] w, input logic expValid, input string tag);
    @(negedge clock_in);
    checkOutput($sformatf("%s_prepulse_mvalid", tag), 32'(m_valid), 32'd0);
    de_data  = w;
    de_valid = 1'b1;
    @(negedge clock_in);
    de_valid = 1'b0;
    checkOutput($sformatf("%s_mvalid", tag), 32'(m_valid), 32'(expValid));
    if (expValid) checkOutput($sformatf("%s_mdata", tag), 32'(m_data), 32'(w));
  endtask

  // One RX frame: a sync-slot word, then 16 data slots alternating IDLE and payload 8'h10+i.
  task automatic rxFrame(input logic [7:0] syncW, input logic expLock, input logic [7:0] expErr,
                         input string tag);
    logic [7:0] w;
    applyStimulus(syncW, 1'b0, $sformatf("%s_sync", tag));
    checkOutput($sformatf("%s_locked", tag), 32'(link_locked), 32'(expLock));
    checkOutput($sformatf("%s_err", tag), 32'(err_count), 32'(expErr));
    for (int i = 1; i <= 16; i++) begin
      w = (i % 2 == 1) ? 8'(8'h10 + i) : 8'h3C;
      applyStimulus(w, expLock && (i % 2 == 1), $sformatf("%s_d%0d", tag, i));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput($sformatf("%s_ser_data", tag), 32'(ser_data), 32'd0);
    checkOutput($sformatf("%s_ser_load", tag), 32'(ser_load), 32'd0);
    checkOutput($sformatf("%s_s_ready", tag), 32'(s_ready), 32'd0);
    checkOutput($sformatf("%s_m_data", tag), 32'(m_data), 32'd0);
    checkOutput($sformatf("%s_m_valid", tag), 32'(m_valid), 32'd0);
    checkOutput($sformatf("%s_locked", tag), 32'(link_locked), 32'd0);
    checkOutput($sformatf("%s_err", tag), 32'(err_count), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] e;
    int sent, readyCycles;
    logic pend;

    // Power-on reset.
    #2 reset_n = 1'b0;
    #10;
    checkAllZero("reset");
    @(negedge clock_in);
    reset_n = 1'b1;

    $display("[TB] idle framing after reset");
    txCheckFromReset("idle");

    $display("[TB] upstream stream 1..20");
    s_data = 8'd1;
    s_valid = 1'b1;
    sent = 0;
    readyCycles = 0;
    pend = 1'b0;
    for (int i = 0; i < 400 && q.size() < 21; i++) begin
      @(negedge clock_in);
      if (pend) begin
        sent++;
        if (sent == 20) s_valid = 1'b0;
        else s_data = 8'(sent + 1);
      end
      if (ser_load) q.push_back(ser_data);
      if (s_ready && s_valid) readyCycles++;
      pend = s_ready && s_valid;
    end
    s_valid = 1'b0;
    checkOutput("stream_loads", 32'(q.size()), 32'd21);
    checkOutput("stream_sent", 32'(sent), 32'd20);
    checkOutput("stream_ready_cycles", 32'(readyCycles), 32'd20);
    for (int k = 0; k < q.size(); k++) begin
      e = (k < 16) ? 8'(k + 1) : ((k == 16) ? 8'hBC : 8'(k));
      checkOutput($sformatf("stream_slot%0d", k), 32'(q[k]), 32'(e));
    end

    $display("[TB] RX acquisition, misses, loss and re-acquire");
    rxFrame(8'hBC, 1'b0, 8'd0, "fA");
    rxFrame(8'hBC, 1'b0, 8'd0, "fB");
    rxFrame(8'hBC, 1'b1, 8'd0, "fC");
    rxFrame(8'hBC, 1'b1, 8'd0, "fD");
    rxFrame(8'h00, 1'b1, 8'd1, "fE");
    rxFrame(8'hBC, 1'b1, 8'd1, "fF");
    rxFrame(8'h00, 1'b1, 8'd2, "fG");
    rxFrame(8'h00, 1'b0, 8'd3, "fH");
    rxFrame(8'hBC, 1'b0, 8'd3, "fI");
    rxFrame(8'hBC, 1'b0, 8'd3, "fJ");
    rxFrame(8'hBC, 1'b1, 8'd3, "fK");

    $display("[TB] async reset mid-lock");
    applyStimulus(8'hBC, 1'b0, "mid_sync");
    applyStimulus(8'h21, 1'b1, "mid_d1");
    applyStimulus(8'h22, 1'b1, "mid_d2");
    @(negedge clock_in);
    #2 reset_n = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge clock_in);
    @(negedge clock_in);
    reset_n = 1'b1;
    txCheckFromReset("restart");
    checkOutput("restart_locked", 32'(link_locked), 32'd0);
    checkOutput("restart_err", 32'(err_count), 32'd0);

`ifdef SERDES_CTRL_LOOPBACK_EN
    begin
      int got;
      logic seenLock;
      $display("[TB] near-end loopback with 8'h55 stream");
      lpbk = 1'b1;
      s_data = 8'h55;
      s_valid = 1'b1;
      seenLock = 1'b0;
      for (int i = 0; i < 1500 && !seenLock; i++) begin
        @(negedge clock_in);
        seenLock = link_locked;
      end
      checkOutput("lpbk_lock", 32'(seenLock), 32'd1);
      got = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clock_in);
        if (m_valid) begin
          got++;
          checkOutput($sformatf("lpbk_word%0d", got), 32'(m_data), 32'h55);
        end
      end
      checkOutput("lpbk_words_seen", 32'(got > 30), 32'd1);
      s_valid = 1'b0;
      lpbk = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
